// File: rtl/rw_arb_pkg.sv
// Shared types for the read/write port arbiter: FSM state encoding and the
// grant-side marker used for fair alternation under contention.
package rw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_WAIT = 2'd3
    } rw_state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_side_e;

endpackage : rw_arb_pkg

// File: rtl/rw_arb_errcnt.sv
// Saturating contention counter. Counts one per cycle that inc_i is high,
// stops at ERR_MAX (never wraps) and flags limit_hit_o while at the limit.
module rw_arb_errcnt #(
    parameter int ERR_MAX = 14,
    parameter int CNT_W   = $clog2(ERR_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             limit_hit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ERR_MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment only while below the limit.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q < LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign limit_hit_o = (count_q >= LIMIT);

endmodule : rw_arb_errcnt

// File: rtl/rw_port_arbiter.sv
// Arbiter sharing one single-port memory between a write requester and a
// read requester. Contention alternates sides; contention cycles are counted.
// Optional checks: define RW_ARB_ASSERT_EN to compile in immediate assertions.
module rw_port_arbiter
    import rw_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int ERR_MAX = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_req,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           wr_gnt,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_gnt,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           mem_wr_en,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic [$clog2(ERR_MAX+1)-1:0]   err_count,
    output logic                           limit_hit
);

    localparam int CNT_W = $clog2(ERR_MAX + 1);

    rw_state_e         state_q;
    rw_state_e         state_d;
    grant_side_e       last_grant_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              contention;

    // Both requesters asking while we are free to grant.
    assign contention = (state_q == IDLE) && wr_req && rd_req;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_req && rd_req) begin
                    state_d = (last_grant_q == GRANT_RD) ? WR : RD;
                end else if (wr_req) begin
                    state_d = WR;
                end else if (rd_req) begin
                    state_d = RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_WAIT;
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WR: begin
                wr_gnt    = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
            RD: begin
                rd_gnt    = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = rd_addr;
            end
            default: ;
        endcase
    end

    // Remember which side was granted last, updated on entry to WR or RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_RD;
        end else if (state_d == WR) begin
            last_grant_q <= GRANT_WR;
        end else if (state_d == RD) begin
            last_grant_q <= GRANT_RD;
        end
    end

    // Capture memory read data at the end of RD_WAIT; hold it between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == RD_WAIT);
            if (state_q == RD_WAIT) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    rw_arb_errcnt #(
        .ERR_MAX (ERR_MAX),
        .CNT_W   (CNT_W)
    ) u_errcnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (contention),
        .count_o     (err_count),
        .limit_hit_o (limit_hit)
    );

`ifdef RW_ARB_ASSERT_EN
    rw_state_e prev_state_q;

    // Track the previous cycle's state for the read-valid check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q <= IDLE;
        end else begin
            prev_state_q <= state_q;
        end
    end

    // Protocol checks sampled on each rising edge outside reset.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_wr_en && mem_rd_en))
                else $error("%m: mem_wr_en and mem_rd_en both high");
            if (rd_valid) begin
                assert (prev_state_q == RD_WAIT)
                    else $error("%m: rd_valid without preceding RD_WAIT");
            end
        end
    end
`else
`endif

endmodule : rw_port_arbiter

// File: tb/tb_rw_port_arbiter.sv
// Directed self-checking bench for rw_port_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge; a behavioural memory answers reads.
module tb_rw_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_gnt;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_gnt;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [3:0] err_count;
    logic       limit_hit;

    int n_cmp;
    int n_bad;

    logic [7:0] mem [256];

    rw_port_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .ERR_MAX (14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err_count (err_count),
        .limit_hit (limit_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Every output packed together, for the all-zero checks.
    logic [33:0] all_out;
    assign all_out = {wr_gnt, rd_gnt, rd_valid, mem_wr_en, mem_rd_en, limit_hit,
                      mem_addr, mem_wdata, rd_data, err_count};

    // Strobe view: {wr_gnt, mem_wr_en, rd_gnt, mem_rd_en, rd_valid}.
    logic [4:0] strobes;
    assign strobes = {wr_gnt, mem_wr_en, rd_gnt, mem_rd_en, rd_valid};

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        rd_addr = 8'h00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (all_out !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        wr_req  = 1'b1;
        wr_addr = 8'h10;
        wr_data = 8'hA5;
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr, mem_wdata, err_count} !== {5'b11000, 8'h10, 8'hA5, 4'd0}) begin
            n_bad++;
            $display("FAIL write_grant: got %b/%h/%h/%0d want 11000/10/a5/0",
                     strobes, mem_addr, mem_wdata, err_count);
        end
        wr_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr, mem_wdata} !== {5'b00000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL write_one_cycle: got %b/%h/%h want 00000/00/00",
                     strobes, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_single_read();
        rd_req  = 1'b1;
        rd_addr = 8'h10;
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr} !== {5'b00110, 8'h10}) begin
            n_bad++;
            $display("FAIL read_grant: got %b/%h want 00110/10", strobes, mem_addr);
        end
        rd_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr, mem_wdata} !== {5'b00000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL read_wait: got %b/%h/%h want 00000/00/00",
                     strobes, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({strobes, rd_data} !== {5'b00001, 8'hA5}) begin
            n_bad++;
            $display("FAIL read_valid: got %b/%h want 00001/a5", strobes, rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b0, 8'hA5}) begin
            n_bad++;
            $display("FAIL read_hold: got %b/%h want 0/a5", rd_valid, rd_data);
        end
    endtask

    // A write request raised during a read is held off until IDLE and not counted.
    task automatic test_back_to_back();
        rd_req  = 1'b1;
        rd_addr = 8'h10;
        @(negedge clk);
        rd_req  = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 8'h30;
        wr_data = 8'h3C;
        @(negedge clk);
        n_cmp++;
        if (strobes !== 5'b00000) begin
            n_bad++;
            $display("FAIL b2b_no_grant_in_wait: got %b want 00000", strobes);
        end
        @(negedge clk);
        n_cmp++;
        if ({strobes, rd_data, err_count} !== {5'b00001, 8'hA5, 4'd0}) begin
            n_bad++;
            $display("FAIL b2b_read_done: got %b/%h/%0d want 00001/a5/0",
                     strobes, rd_data, err_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr, mem_wdata, err_count} !== {5'b11000, 8'h30, 8'h3C, 4'd0}) begin
            n_bad++;
            $display("FAIL b2b_write_after: got %b/%h/%h/%0d want 11000/30/3c/0",
                     strobes, mem_addr, mem_wdata, err_count);
        end
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_contention();
        do_reset();
        wr_req  = 1'b1;
        wr_addr = 8'h20;
        wr_data = 8'h5A;
        rd_req  = 1'b1;
        rd_addr = 8'h10;
        @(negedge clk);
        n_cmp++;
        if ({strobes, err_count} !== {5'b11000, 4'd1}) begin
            n_bad++;
            $display("FAIL contention_write_first: got %b/%0d want 11000/1", strobes, err_count);
        end
        wr_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({strobes, err_count} !== {5'b00000, 4'd1}) begin
            n_bad++;
            $display("FAIL contention_idle: got %b/%0d want 00000/1", strobes, err_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr, err_count} !== {5'b00110, 8'h10, 4'd1}) begin
            n_bad++;
            $display("FAIL contention_read_next: got %b/%h/%0d want 00110/10/1",
                     strobes, mem_addr, err_count);
        end
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            n_bad++;
            $display("FAIL contention_read_data: got %b/%h want 1/a5", rd_valid, rd_data);
        end
    endtask

    // Both requests held: grants alternate W,R,...; 20 IDLE cycles occur at
    // cycles 0,2,5,7,...,45,47 so the count reaches 14 after cycle 32.
    task automatic test_saturation();
        logic [1:0] exp_side;
        int         n_grants;
        do_reset();
        exp_side = 2'b10;
        n_grants = 0;
        wr_req   = 1'b1;
        wr_addr  = 8'h40;
        wr_data  = 8'h77;
        rd_req   = 1'b1;
        rd_addr  = 8'h10;
        for (int i = 1; i <= 49; i++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_wr_en && mem_rd_en) begin
                n_bad++;
                $display("FAIL sat_exclusive: cycle %0d both enables high", i);
            end
            if (wr_gnt || rd_gnt) begin
                n_cmp++;
                if ({wr_gnt, rd_gnt} !== exp_side) begin
                    n_bad++;
                    $display("FAIL sat_alternate: cycle %0d got %b want %b",
                             i, {wr_gnt, rd_gnt}, exp_side);
                end
                exp_side = ~exp_side;
                n_grants++;
            end
            if (i == 13) begin
                n_cmp++;
                if ({err_count, limit_hit} !== {4'd6, 1'b0}) begin
                    n_bad++;
                    $display("FAIL sat_mid_count: got %0d/%b want 6/0", err_count, limit_hit);
                end
            end
            if (i == 32) begin
                n_cmp++;
                if ({err_count, limit_hit} !== {4'd13, 1'b0}) begin
                    n_bad++;
                    $display("FAIL sat_below_limit: got %0d/%b want 13/0", err_count, limit_hit);
                end
            end
            if (i == 33) begin
                n_cmp++;
                if ({err_count, limit_hit} !== {4'd14, 1'b1}) begin
                    n_bad++;
                    $display("FAIL sat_at_limit: got %0d/%b want 14/1", err_count, limit_hit);
                end
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_cmp++;
        if (n_grants !== 20) begin
            n_bad++;
            $display("FAIL sat_grant_total: got %0d want 20", n_grants);
        end
        @(negedge clk);
        n_cmp++;
        if ({err_count, limit_hit} !== {4'd14, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_no_wrap: got %0d/%b want 14/1", err_count, limit_hit);
        end
    endtask

    task automatic test_reset_during_read();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 8'h30;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== 34'h0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL abort_no_valid: got %b/%h want 0/00", rd_valid, rd_data);
        end
        rst_n   = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 8'h50;
        wr_data = 8'h11;
        rd_req  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr, err_count} !== {5'b11000, 8'h50, 4'd1}) begin
            n_bad++;
            $display("FAIL abort_next_write: got %b/%h/%0d want 11000/50/1",
                     strobes, mem_addr, err_count);
        end
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({strobes, mem_addr} !== {5'b00110, 8'h30}) begin
            n_bad++;
            $display("FAIL abort_then_read: got %b/%h want 00110/30", strobes, mem_addr);
        end
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_first_contention();
        test_saturation();
        test_reset_during_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rw_port_arbiter
